pipelined_rca: RTL
==================

Name: pipelined_rca

Overview:
Parametrised, pipelined ripple-carry adder. Adds two WIDTH-bit operands plus carry-in. The carry chain is cut into STAGES = WIDTH/CHUNK register stages, each adding one CHUNK-bit slice. Sustains one addition per clock with a valid/ready handshake on input and output. Used in datapaths where a full-width combinational ripple adder cannot meet timing.

Parameters:
WIDTH, 32, operand and sum width in bits; must be a multiple of CHUNK.
CHUNK, 8, bits added per pipeline stage. STAGES = WIDTH/CHUNK is derived and gives the latency.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operands a, b, cin are valid
in_ready  output  1  block can accept an operand set this cycle
a  input  WIDTH  operand A, unsigned
b  input  WIDTH  operand B, unsigned
cin  input  1  carry-in into bit 0
out_valid  output  1  sum and cout are valid
out_ready  input  1  downstream accepts the result
sum  output  WIDTH  a + b + cin, modulo 2^WIDTH
cout  output  1  carry out of bit WIDTH-1

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. While rst is high at a clk edge:
  - every stage valid bit is cleared;
  - every stage data register (partial sum, delayed operand slices, carry) is cleared to 0;
  - outputs after the edge: out_valid=0, sum=0, cout=0, in_ready=1.
- Transfers: input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
- Stage k (0..STAGES-1):
  - adds slice k of a and b plus the carry registered by stage k-1 (cin for stage 0), using the chunk adder;
  - registers the resulting CHUNK sum bits and the chunk carry;
  - carries forward the already-computed lower sum bits and the not-yet-added upper operand slices.
- Latency: exactly STAGES cycles from input transfer to out_valid, with no stall. Throughput is one transfer per cycle.
- Per-stage flow control:
  - stage_ready[k] = !valid[k] || stage_ready[k+1];
  - stage_ready[STAGES] = out_ready;
  - in_ready = stage_ready[0], a combinational path from out_ready.
- A stage loads only when its ready is high; otherwise it holds its data and valid bit unchanged.
- Ordering: results leave in acceptance order. No result is dropped or duplicated.
- Full pipeline with out_ready=0: in_ready=0 and all data is held stable.
- Full pipeline with out_ready=1 and in_valid=1 in the same cycle: the output transfer and the input transfer both occur; the pipeline advances.
- Reset mid-operation: in-flight results are discarded and none appear after reset.
- Held output: sum and cout stay stable while out_valid=1 and out_ready=0.
- Elaboration: WIDTH % CHUNK != 0 or CHUNK < 1 is an elaboration error ($error).

Optional Feature:
Macro PIPELINED_RCA_OVERFLOW_EN.
- Defined: adds output port ovf (1 bit), the two's-complement signed overflow.
  - ovf = carry into the MSB XOR cout.
  - It is pipelined with sum and valid with out_valid.
  - Reset value 0.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Package pipelined_rca_pkg:
  - default WIDTH and CHUNK constants;
  - function num_stages(width, chunk).
- Sub-module rca_chunk (parameter CHUNK):
  - combinational CHUNK-bit ripple adder built from per-bit sum = a^b^c and carry = majority(a,b,c);
  - outputs sum, cout and carry-into-MSB (the last is needed for ovf).
- One rca_chunk instance per stage, generated in the top module.

Test Plan (WIDTH=16, CHUNK=4, STAGES=4):
1. Reset: rst=1 for 2 cycles with in_valid=1 -> out_valid=0, sum=0x0000, cout=0, in_ready=1; no output later.
2. Full carry ripple: a=0xFFFF, b=0x0001, cin=0, out_ready=1 -> out_valid exactly 4 cycles after accept, sum=0x0000, cout=1.
3. Streaming: 8 back-to-back ops a=i*0x1111, b=0x0F0F, cin=i[0], out_ready=1 -> 8 results on 8 consecutive cycles starting at cycle 4, each equal to the reference sum, in order.
4. Backpressure: out_ready=0 while presenting 6 ops -> 4 accepted, then in_ready=0; the 5th is held. Release out_ready -> 6 results in order, none lost or duplicated, sum stable while stalled.
5. Reset mid-flight: 3 ops accepted, rst=1 for 1 cycle at cycle 2 -> out_valid=0 the next cycle and no stale result ever appears; a new op after reset returns correctly at +4.
6. Carry-in and overflow: a=0x7FFF, b=0x0000, cin=1 -> sum=0x8000, cout=0; with PIPELINED_RCA_OVERFLOW_EN, ovf=1. Also a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.

Source files
------------

// File: rtl/pipelined_rca_pkg.sv
// Shared constants and helpers for the pipelined ripple-carry adder.
package pipelined_rca_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CHUNK = 8;

    // An illegal chunk still yields one stage so declarations stay legal
    // while the top module reports the parameter error.
    function automatic int num_stages(input int width, input int chunk);
        if (chunk < 1) begin
            return 1;
        end
        return width / chunk;
    endfunction

endpackage

// File: rtl/pipelined_rca_chunk.sv
// rca_chunk: combinational CHUNK-bit ripple adder, one per pipeline stage.
// cmsb is the carry into the top bit, used for signed overflow.
module rca_chunk
    import pipelined_rca_pkg::*;
#(
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
    end

    assign cout = c[CHUNK];
    assign cmsb = c[CHUNK-1];

endmodule

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder: one CHUNK-bit slice per stage, STAGES cycles
// of latency, one result per clock. Define PIPELINED_RCA_OVERFLOW_EN for ovf.
module pipelined_rca
    import pipelined_rca_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPELINED_RCA_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int STAGES = num_stages(WIDTH, CHUNK);

    if ((CHUNK < 1) || ((WIDTH % ((CHUNK < 1) ? 1 : CHUNK)) != 0)) begin : g_param_check
        $error("pipelined_rca: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)",
               WIDTH, CHUNK);
    end

    // Handshake: a transfer happens on a clock edge where valid && ready.
    // valid never waits for ready; ready of a stage means "empty or the
    // stage after it moves this cycle", so in_ready combinationally follows
    // out_ready through the chain.
    logic [STAGES:0]   stage_ready;
    logic [STAGES-1:0] valid;
    logic [STAGES-1:0] carry;
    logic [WIDTH-1:0]  psum [STAGES];
    logic [WIDTH-1:0]  opa  [STAGES];
    logic [WIDTH-1:0]  opb  [STAGES];

    always_comb begin
        stage_ready         = '0;
        stage_ready[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            stage_ready[k] = !valid[k] || stage_ready[k + 1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             v_in;
        logic             c_in;
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] s_in;
        logic [CHUNK-1:0] chunk_sum;
        logic             chunk_cout;
        logic             chunk_cmsb;
        logic             v_q;
        logic             c_q;
        logic [WIDTH-1:0] s_q;
        logic [WIDTH-1:0] a_q;
        logic [WIDTH-1:0] b_q;

        if (k == 0) begin : g_head
            assign v_in = in_valid;
            assign c_in = cin;
            assign a_in = a;
            assign b_in = b;
            assign s_in = '0;
        end else begin : g_body
            assign v_in = valid[k-1];
            assign c_in = carry[k-1];
            assign a_in = opa[k-1];
            assign b_in = opb[k-1];
            assign s_in = psum[k-1];
        end

        rca_chunk #(
            .CHUNK (CHUNK)
        ) u_chunk (
            .a    (a_in[CHUNK-1:0]),
            .b    (b_in[CHUNK-1:0]),
            .cin  (c_in),
            .sum  (chunk_sum),
            .cout (chunk_cout),
            .cmsb (chunk_cmsb)
        );

        // Operands shift down so the next slice always sits at bit 0; the
        // partial sum shifts down so finished slices land in place at the end.
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
                a_q <= '0;
                b_q <= '0;
            end else if (stage_ready[k]) begin
                v_q <= v_in;
                c_q <= chunk_cout;
                s_q <= (s_in >> CHUNK) | (WIDTH'(chunk_sum) << (WIDTH - CHUNK));
                a_q <= a_in >> CHUNK;
                b_q <= b_in >> CHUNK;
            end
        end

        assign valid[k] = v_q;
        assign carry[k] = c_q;
        assign psum[k]  = s_q;
        assign opa[k]   = a_q;
        assign opb[k]   = b_q;

`ifdef PIPELINED_RCA_OVERFLOW_EN
        if (k == STAGES - 1) begin : g_ovf
            logic ovf_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (stage_ready[k]) begin
                    ovf_q <= chunk_cmsb ^ chunk_cout;
                end
            end

            assign ovf = ovf_q;
        end
`endif
    end

    assign in_ready  = stage_ready[0];
    assign out_valid = valid[STAGES-1];
    assign sum       = psum[STAGES-1];
    assign cout      = carry[STAGES-1];

endmodule
